// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default width, NOP encoding, fetch FSM states
// and the J-type target helper.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT,
    IF_RUN,
    IF_HALT
  } if_state_t;

  // J-type target: upper nibble of the delay-slot PC, index field, word aligned.
  function automatic logic [31:0] jump_target(input logic [3:0] pc4_hi,
                                              input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control inputs from ID, instruction memory port and the
// IF/ID register outputs. master = if_stage, slave = surrounding datapath.
interface if_stage_if #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
);

  logic                  stall;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [25:0]           jump_idx;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic [DATA_WIDTH-1:0] if_id_pc4;
  logic                  if_id_valid;
  logic                  halted;
  logic                  misalign_err;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_idx, imem_instr,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, misalign_err
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_idx, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, misalign_err
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: redirect target, PC+4 and end-of-image test.
// IF_STAGE_MISALIGN_CHECK_EN: when defined, a branch target with [1:0] != 0 is
// reported through redirect_bad instead of being silently aligned.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = 10
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [3:0]            pc4_hi,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [25:0]           jump_idx,
  output logic                  redirect,
  output logic                  redirect_bad,
  output logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  at_limit
);

  localparam logic [DATA_WIDTH-1:0] Limit = DATA_WIDTH'(MEM_DEPTH * 4);

  logic [DATA_WIDTH-1:0] raw_target;

  // Jump beats branch; target is always delivered word aligned.
  always_comb begin
    raw_target = jump ? jump_target(pc4_hi, jump_idx) : branch_target;
    redirect   = jump | branch_taken;
    target     = {raw_target[DATA_WIDTH-1:2], 2'b00};
    pc_plus4   = pc + DATA_WIDTH'(4);
    at_limit   = pc >= Limit;
  end

`ifdef IF_STAGE_MISALIGN_CHECK_EN
  assign redirect_bad = redirect & (|raw_target[1:0]);
`else
  logic unused_lo;
  assign unused_lo    = ^raw_target[1:0];
  assign redirect_bad = 1'b0;
`endif

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, BOOT/RUN/HALT FSM.
// IF_STAGE_MISALIGN_CHECK_EN: when defined, misaligned redirects halt the stage
// and set the sticky misalign_err flag; otherwise targets are word aligned.
module if_stage
  import mips_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           MEM_DEPTH  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  if_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;

  logic                  redirect, redirect_bad, at_limit;
  logic [DATA_WIDTH-1:0] target, pc_plus4;

  pc_next_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_pc_next_mux (
    .pc            (pc_q),
    .pc4_hi        (pc4_q[DATA_WIDTH-1 -: 4]),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_idx      (bus.jump_idx),
    .redirect      (redirect),
    .redirect_bad  (redirect_bad),
    .target        (target),
    .pc_plus4      (pc_plus4),
    .at_limit      (at_limit)
  );

  // Next-state and next PC / IF/ID contents; redirect > stall > limit > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      IF_BOOT: state_d = IF_RUN;
      IF_RUN, IF_HALT: begin
        if (redirect) begin
          instr_d = DATA_WIDTH'(NOP_INSTR);
          pc4_d   = '0;
          valid_d = 1'b0;
          if (redirect_bad) begin
            state_d = IF_HALT;
          end else begin
            pc_d    = target;
            state_d = IF_RUN;
          end
        end else if (state_q == IF_HALT || bus.stall) begin
          // hold everything
        end else if (at_limit) begin
          state_d = IF_HALT;
          instr_d = DATA_WIDTH'(NOP_INSTR);
          pc4_d   = '0;
          valid_d = 1'b0;
        end else begin
          instr_d = bus.imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end
      default: state_d = IF_BOOT;
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_STAGE_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky until reset; BOOT ignores inputs so it cannot set the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (state_q != IF_BOOT && redirect_bad) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == IF_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a 10-word program image.
module tb_if_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  if_stage_if #(.DATA_WIDTH(32)) bus ();

  if_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .MEM_DEPTH  (10)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [10];

  initial begin
    mem[0] = 32'h0224_0020;
    mem[1] = 32'h021E_C022;
    mem[2] = 32'h0128_5024;
    mem[3] = 32'h8C08_0000;
    mem[4] = 32'hAC09_0004;
    mem[5] = 32'h0109_5020;
    mem[6] = 32'h014B_6020;
    mem[7] = 32'h1100_0004;
    mem[8] = 32'h016C_6822;
    mem[9] = 32'h080A_0000;
  end

  // Combinational instruction memory; out-of-image reads return a marker.
  assign bus.imem_instr = (bus.imem_addr < 32'd40) ? mem[bus.imem_addr[5:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_idx      = 26'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  bus.imem_addr,    32'h0);
    check({tag, "_instr"}, bus.if_id_instr,  32'h0);
    check({tag, "_pc4"},   bus.if_id_pc4,    32'h0);
    check({tag, "_valid"}, {31'h0, bus.if_id_valid},  32'h0);
    check({tag, "_halt"},  {31'h0, bus.halted},       32'h0);
    check({tag, "_mis"},   {31'h0, bus.misalign_err}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_ctl();
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // BOOT edge, then stream
    step();
    check("boot_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("boot_pc", bus.imem_addr, 32'h0);
    step();
    check("s0_instr", bus.if_id_instr, 32'h0224_0020);
    check("s0_pc4", bus.if_id_pc4, 32'h4);
    check("s0_valid", {31'h0, bus.if_id_valid}, 32'h1);
    step();
    check("s1_instr", bus.if_id_instr, 32'h021E_C022);
    check("s1_pc", bus.imem_addr, 32'h8);

    // Stall for three edges at pc 0x8
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.imem_addr, 32'h8);
      check("stall_instr", bus.if_id_instr, 32'h021E_C022);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_instr", bus.if_id_instr, 32'h0128_5024);

    // Branch together with stall: redirect wins
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h1C;
    bus.stall         = 1'b1;
    step();
    clear_ctl();
    check("br_pc", bus.imem_addr, 32'h1C);
    check("br_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("br_instr0", bus.if_id_instr, 32'h0);
    step();
    check("br_instr", bus.if_id_instr, 32'h1100_0004);
    check("br_pc4", bus.if_id_pc4, 32'h20);

    // Set up if_id_pc4 = 0x10 via a branch to 0xC
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hC;
    step();
    clear_ctl();
    step();
    check("pre_j_pc4", bus.if_id_pc4, 32'h10);

    // Jump and branch together: jump wins
    bus.jump          = 1'b1;
    bus.jump_idx      = 26'h2;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h1C;
    step();
    clear_ctl();
    check("j_pc", bus.imem_addr, 32'h8);
    check("j_valid", {31'h0, bus.if_id_valid}, 32'h0);
    step();
    check("j_instr", bus.if_id_instr, 32'h0128_5024);

    // Run to the end of the image
    for (int a = 12; a <= 36; a += 4) begin
      step();
      check("run_instr", bus.if_id_instr, mem[a/4]);
      check("run_pc4", bus.if_id_pc4, 32'(a + 4));
    end
    check("end_pc", bus.imem_addr, 32'h28);
    check("end_nohalt", {31'h0, bus.halted}, 32'h0);
    step();
    check("halt", {31'h0, bus.halted}, 32'h1);
    check("halt_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("halt_pc", bus.imem_addr, 32'h28);
    bus.stall = 1'b1;
    step();
    check("halt_stall", {31'h0, bus.halted}, 32'h1);
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0;
    step();
    clear_ctl();
    check("resume_halt", {31'h0, bus.halted}, 32'h0);
    check("resume_pc", bus.imem_addr, 32'h0);
    step();
    check("resume_instr", bus.if_id_instr, 32'h0224_0020);

    // Misaligned redirect to 0x6 from pc 0x4
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h6;
    step();
    clear_ctl();
`ifdef IF_STAGE_MISALIGN_CHECK_EN
    check("mis_halt", {31'h0, bus.halted}, 32'h1);
    check("mis_err", {31'h0, bus.misalign_err}, 32'h1);
    check("mis_pc", bus.imem_addr, 32'h4);
    check("mis_valid", {31'h0, bus.if_id_valid}, 32'h0);
    step();
    check("mis_sticky", {31'h0, bus.misalign_err}, 32'h1);
`else
    check("mis_pc", bus.imem_addr, 32'h4);
    check("mis_err", {31'h0, bus.misalign_err}, 32'h0);
    check("mis_valid", {31'h0, bus.if_id_valid}, 32'h0);
    step();
    check("mis_instr", bus.if_id_instr, 32'h021E_C022);
`endif

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    #3;
    rst_n = 1'b1;
    step();
    check("reboot_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("reboot_pc", bus.imem_addr, 32'h0);
    step();
    check("reboot_instr", bus.if_id_instr, 32'h0224_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS datapath. Sits directly upstream of the instruction memory: owns the program counter, drives the word-aligned fetch address, and captures the returned instruction into the IF/ID pipeline register for decode. Handles stall, branch/jump redirects with wrong-path squash, and halts at the end of the program image.

## Interface
- `DATA_WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `MEM_DEPTH`, 10: instruction memory depth in words. The fetch limit is `MEM_DEPTH*4` bytes.
- `clk` in 1: clock. Everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the PC and IF/ID contents.
- `branch_taken` in 1: redirect to `branch_target`. Resolved in ID.
- `branch_target` in DATA_WIDTH: full byte address.
- `jump` in 1: redirect to the jump target.
- `jump_idx` in 26: J-type index field.
- `imem_addr` out DATA_WIDTH: byte address to the instruction memory. Equals `pc`, combinationally.
- `imem_instr` in DATA_WIDTH: instruction returned combinationally by the memory.
- `if_id_instr` out DATA_WIDTH: registered instruction. 0 (NOP) when invalid.
- `if_id_pc4` out DATA_WIDTH: registered PC+4 of `if_id_instr`.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: the stage is in HALT.
- `misalign_err` out 1: sticky misaligned-redirect flag. See Configuration.

## Operation
- FSM states: BOOT, RUN, HALT. Reset state is BOOT.
- **BOOT**
  - Lasts exactly one edge.
  - The PC is not advanced and IF/ID is not loaded.
  - Goes to RUN unconditionally. Inputs are ignored.
- **RUN**, evaluated in priority order:
  1. Redirect (`jump` or `branch_taken`):
     - `pc` takes the target. `jump` has priority over `branch_taken`.
     - The jump target is {`if_id_pc4`[31:28], `jump_idx`, 2'b00}.
     - IF/ID is squashed: `valid`=0, `instr`=0, `pc4`=0.
     - A redirect overrides `stall`.
  2. `stall`: `pc` and IF/ID hold.
  3. `pc` ≥ `MEM_DEPTH*4`: go to HALT. IF/ID is squashed and `pc` holds.
  4. Otherwise:
     - `if_id_instr`←`imem_instr`, `if_id_pc4`←`pc`+4, `if_id_valid`←1.
     - `pc`←`pc`+4.
- **HALT**
  - `pc` holds. IF/ID stays invalid.
  - A redirect loads `pc` and returns to RUN. `stall` is ignored.
- Arithmetic:
  - PC+4 is modulo 2^DATA_WIDTH. 0xFFFF_FFFC+4 = 0.
  - The limit comparison is unsigned.

## Timing
- Reset values:
  - `pc` = `imem_addr` = `RESET_PC`.
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0.
  - `halted` = 0, `misalign_err` = 0.
- Fetch latency: the instruction at `pc` appears on `if_id_instr` one edge after `imem_addr` = `pc`.
- Throughput: one instruction per cycle in RUN with no stall.
- Redirect penalty: one bubble. The edge that loads the target also emits `valid`=0. The target instruction appears on the following edge.
- `halted` is registered and asserts on the edge that enters HALT.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - After release, the stage goes through BOOT again.
- `stall` and redirect inputs are sampled only at the rising edge.

## Configuration
- `IF_STAGE_MISALIGN_CHECK_EN`
  - **Defined**:
    - A redirect whose target has [1:0] ≠ 0 is not taken.
    - The stage enters HALT and IF/ID is squashed.
    - `misalign_err` is set and stays set until reset.
  - **Undefined**:
    - Target bits [1:0] are forced to 00 and the redirect proceeds.
    - `misalign_err` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_WIDTH` default.
  - `NOP_INSTR` = 32'h0.
  - `if_state_t` enum {IF_BOOT, IF_RUN, IF_HALT}.
- Sub-module `pc_next_mux`:
  - Purely combinational.
  - Computes the next PC and the redirect/halt decision from the current `pc`, `if_id_pc4`, the redirect inputs and `MEM_DEPTH`.
  - The `if_stage` top level owns the FSM and all registers.

## Test plan
- **Reset and stream**:
  - Release `rst_n`. With the standard 10-word program image, the second edge gives `if_id_instr`=0x02240020, `pc4`=0x4, `valid`=1.
  - The next edges give 0x021EC022, then 0x01285024.
- **Stall**:
  - Hold `stall` for 3 cycles while `pc`=0x8. `pc` stays 0x8 and `if_id_instr` stays 0x021EC022.
  - On release, the next edge gives 0x01285024.
- **Branch redirect, and stall+branch in the same cycle**:
  - `branch_taken`=1, `branch_target`=0x1C, `stall`=1. Next edge: `pc`=0x1C, `valid`=0.
  - The edge after: `if_id_instr`=0x11000004.
- **Jump**:
  - With `if_id_pc4`=0x10, drive `jump`=1 and `jump_idx`=0x2 together with `branch_taken`=1. The jump wins: `pc`=0x8.
  - One bubble, then `if_id_instr`=0x01285024.
- **End of image**:
  - After fetching 0x080A0000 at `pc`=0x24, `pc`=0x28. The next edge sets `halted`=1 and `valid`=0.
  - `branch_target`=0x0 resumes: `halted`=0, then 0x02240020 appears.
- **Misalign and mid-run reset**:
  - With the macro defined, redirect to 0x6: `halted`=1, `misalign_err`=1, `pc` unchanged.
  - Then assert `rst_n`=0 mid-cycle: all outputs clear asynchronously, and `misalign_err` returns to 0.
